// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core load/store port.
// Accepts one request at a time, performs a word read or byte-strobed write
// on an internal synchronous array, and answers with a one-cycle read_valid
// or write_ready pulse LATENCY cycles after the accept edge.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   address           byte address, sampled at accept
//   read_enable       read request (level, held until read_valid)
//   read_data         read word, valid with read_valid, held otherwise
//   read_valid        one-cycle read response pulse
//   write_data, strb  store data and byte-lane enables, sampled at accept
//   write_enable      write request (level, held until write_ready)
//   write_ready       one-cycle write completion pulse
//   access_fault      fault flag on the response cycle (DMEM_FAULT_EN only)
//
// Optional feature macro: DMEM_FAULT_EN (misaligned / out-of-range checks).
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        read_valid,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic [3:0]  strb,
  output logic        write_ready
`ifdef DMEM_FAULT_EN
  ,
  output logic        access_fault
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       strb_q;
  logic             wr_q;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             req_c;
  logic             go_resp_c;
  logic [31:0]      op_addr_c;
  logic [31:0]      op_wdata_c;
  logic [3:0]       op_strb_c;
  logic             op_wr_c;
  logic [31:0]      off_c;
  logic [AW-1:0]    idx_c;
  logic             fault_c;
  logic             mem_we_c;
  logic             unused_off_c;

  // The operation committing on this edge: live inputs when LATENCY==1
  // (accept and commit share an edge), latched request otherwise.
  always_comb begin
    req_c      = read_enable | write_enable;
    go_resp_c  = ((state == IDLE) && req_c && (LATENCY == 1)) ||
                 ((state == WAIT) && (cnt == CNT_W'(1)));
    op_addr_c  = (state == IDLE) ? address      : addr_q;
    op_wdata_c = (state == IDLE) ? write_data   : wdata_q;
    op_strb_c  = (state == IDLE) ? strb         : strb_q;
    op_wr_c    = (state == IDLE) ? write_enable : wr_q;
    off_c      = op_addr_c - BASE_ADDR;
    idx_c      = off_c[AW+1:2];
`ifdef DMEM_FAULT_EN
    fault_c    = (op_addr_c[1:0] != 2'b00) || ({1'b0, off_c} >= SPAN);
`else
    fault_c    = 1'b0;
`endif
    // rst gates the write so a request seen during reset never lands.
    mem_we_c   = go_resp_c & op_wr_c & ~fault_c & rst;
  end

  assign unused_off_c = ^{off_c, SPAN};

  // Data array: not reset, byte-lane writes on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (op_strb_c[i]) mem[idx_c][8*i +: 8] <= op_wdata_c[8*i +: 8];
      end
    end
  end

  // Request FSM and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      wr_q         <= 1'b0;
      read_data    <= '0;
      read_valid   <= 1'b0;
      write_ready  <= 1'b0;
`ifdef DMEM_FAULT_EN
      access_fault <= 1'b0;
`endif
    end else begin
      read_valid   <= 1'b0;
      write_ready  <= 1'b0;
`ifdef DMEM_FAULT_EN
      access_fault <= 1'b0;
`endif
      if (go_resp_c) begin
        if (op_wr_c) begin
          write_ready <= 1'b1;
        end else begin
          read_valid <= 1'b1;
          read_data  <= fault_c ? 32'h0 : mem[idx_c];
        end
`ifdef DMEM_FAULT_EN
        access_fault <= fault_c;
`endif
      end

      case (state)
        IDLE: begin
          if (req_c) begin
            addr_q  <= address;
            wdata_q <= write_data;
            strb_q  <= strb;
            // Both enables high is a write.
            wr_q    <= write_enable;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (LATENCY 1 and 3)
// driven by randomized and directed requests; expected responses come from
// a word-array model and are checked by a monitor on each response pulse.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  typedef struct {
    bit          wr;
    bit          chk;
    logic [31:0] data;
    bit          fault;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_d      [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic [3:0]  strb       [2];
  logic        re         [2];
  logic        we         [2];
  logic        rv         [2];
  logic        wrdy       [2];
  logic        af         [2];

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_rd [2];
  logic [31:0] mdl     [2][DEPTH];
  bit          known   [2][DEPTH];

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst_d[0]), .address(address[0]), .read_enable(re[0]),
    .read_data(read_data[0]), .read_valid(rv[0]), .write_data(write_data[0]),
    .write_enable(we[0]), .strb(strb[0]), .write_ready(wrdy[0])
`ifdef DMEM_FAULT_EN
    , .access_fault(af[0])
`endif
  );

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst_d[1]), .address(address[1]), .read_enable(re[1]),
    .read_data(read_data[1]), .read_valid(rv[1]), .write_data(write_data[1]),
    .write_enable(we[1]), .strb(strb[1]), .write_ready(wrdy[1])
`ifdef DMEM_FAULT_EN
    , .access_fault(af[1])
`endif
  );

`ifndef DMEM_FAULT_EN
  assign af[0] = 1'b0;
  assign af[1] = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit mdl_fault(input logic [31:0] a);
`ifdef DMEM_FAULT_EN
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
`else
    return (a == 32'h0) && 1'b0;
`endif
  endfunction

  function automatic int mdl_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) >> 2;
    return int'(w % 32'(DEPTH));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  task automatic mon(input int d);
    exp_t e;
    int   n;
    if (!(rv[d] || wrdy[d])) return;
    n = (d == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      chk($sformatf("d%0d_spurious_pulse", d), {30'h0, rv[d], wrdy[d]}, 32'h0);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("d%0d_both_pulses", d), 32'(rv[d] & wrdy[d]), 32'h0);
    chk($sformatf("d%0d_kind", d), 32'(wrdy[d]), 32'(e.wr));
    chk($sformatf("d%0d_resp_cycle", d), cyc, e.cyc);
    chk($sformatf("d%0d_fault", d), 32'(af[d]), 32'(e.fault));
    if (rv[d]) begin
      if (e.chk) chk($sformatf("d%0d_read_data", d), read_data[d], e.data);
      last_rd[d] = read_data[d];
    end else begin
      chk($sformatf("d%0d_read_data_hold", d), read_data[d], last_rd[d]);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  // Issue one request, hold it until its response pulse, update the model.
  task automatic do_req(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s);
    exp_t e;
    int   ix;
    bit   got;
    @(posedge clk); #1;
    address[d] = a; write_data[d] = wd; strb[d] = s; re[d] = rd; we[d] = wr;
    ix = mdl_idx(a);
    e.wr = wr; e.fault = mdl_fault(a); e.cyc = cyc + lat(d); e.chk = 1'b1; e.data = 32'h0;
    if (wr) begin
      if (!e.fault) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) mdl[d][ix][8*i +: 8] = wd[8*i +: 8];
        if (s == 4'hF) known[d][ix] = 1'b1;
      end
    end else if (!e.fault) begin
      e.data = mdl[d][ix];
      e.chk  = known[d][ix];
    end
    push_exp(d, e);
    @(posedge clk); #1;
    // Request already accepted; these changes must not matter.
    address[d] = $urandom; write_data[d] = $urandom; strb[d] = 4'($urandom);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rv[d] || wrdy[d]) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk($sformatf("d%0d_response_timeout", d), 32'h0, 32'h1);
      if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    end
  endtask

  task automatic idle(input int d, input int n);
    @(posedge clk); #1;
    re[d] = 1'b0; we[d] = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Write accepted, then reset during WAIT: no pulse, memory untouched.
  task automatic reset_abort(input int d, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    address[d] = a; write_data[d] = wd; strb[d] = 4'hF; re[d] = 1'b0; we[d] = 1'b1;
    @(posedge clk); #1;
    we[d] = 1'b0; rst_d[d] = 1'b0; last_rd[d] = 32'h0;
    #1;
    chk($sformatf("d%0d_abort_rv", d), 32'(rv[d]), 32'h0);
    chk($sformatf("d%0d_abort_wr", d), 32'(wrdy[d]), 32'h0);
    chk($sformatf("d%0d_abort_rdata", d), read_data[d], 32'h0);
    repeat (4) @(posedge clk);
    #1 rst_d[d] = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic directed(input int d);
    do_req(d, 0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    do_req(d, 1, 0, 32'h8000_0010, 32'h0, 4'h0);
    do_req(d, 0, 1, 32'h8000_0020, 32'h1122_3344, 4'hF);
    do_req(d, 0, 1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
    do_req(d, 1, 0, 32'h8000_0020, 32'h0, 4'hF);
    idle(d, 2);
    do_req(d, 1, 1, 32'h8000_0040, 32'h5566_7788, 4'hF);
    do_req(d, 1, 0, 32'h8000_0040, 32'h0, 4'h0);
    do_req(d, 0, 1, 32'h8000_0040, 32'hFFFF_FFFF, 4'h0);
    do_req(d, 1, 0, 32'h8000_0040, 32'h0, 4'h0);
    do_req(d, 0, 1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF);
    do_req(d, 1, 0, 32'h8000_0002, 32'h0, 4'h0);
    do_req(d, 1, 0, 32'h7FFF_FFFC, 32'h0, 4'h0);
    do_req(d, 0, 1, 32'h8000_4000, 32'h1357_9BDF, 4'hF);
    do_req(d, 1, 0, 32'h8000_0000, 32'h0, 4'h0);
    do_req(d, 1, 0, 32'h8000_0013, 32'h0, 4'h0);
    idle(d, 1);
  endtask

  task automatic random_phase(input int d, input int n);
    logic [31:0] a;
    int          r;
    for (int t = 0; t < n; t++) begin
      a = BASE + 32'($urandom_range(0, 31)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      r = $urandom_range(0, 9);
      if (r < 4)      do_req(d, 1, 0, a, $urandom, 4'($urandom));
      else if (r < 9) do_req(d, 0, 1, a, $urandom, 4'($urandom));
      else            do_req(d, 1, 1, a, $urandom, 4'hF);
      if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(0, 2));
    end
    idle(d, 1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_d[d] = 1'b0; re[d] = 1'b0; we[d] = 1'b0; strb[d] = 4'h0;
      address[d] = 32'h0; write_data[d] = 32'h0; last_rd[d] = 32'h0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_reset_rv", d), 32'(rv[d]), 32'h0);
      chk($sformatf("d%0d_reset_wr", d), 32'(wrdy[d]), 32'h0);
      chk($sformatf("d%0d_reset_rdata", d), read_data[d], 32'h0);
      chk($sformatf("d%0d_reset_fault", d), 32'(af[d]), 32'h0);
    end
    @(posedge clk); #1;
    rst_d[0] = 1'b1; rst_d[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        chk($sformatf("d%0d_idle_outputs", d),
            {read_data[d][29:0], rv[d], wrdy[d]} | 32'(af[d]), 32'h0);
    end

    directed(0);
    directed(1);

    do_req(1, 0, 1, 32'h8000_0044, 32'hCAFE_F00D, 4'hF);
    reset_abort(1, 32'h8000_0044, 32'h1234_5678);
    do_req(1, 1, 0, 32'h8000_0044, 32'h0, 4'h0);
    idle(1, 1);

    random_phase(0, 80);
    random_phase(1, 80);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the core's load/store port: accepts one request at a time on `read_enable`/`write_enable`, performs a word-wide read or a byte-strobed write on an internal synchronous array, and acknowledges with a one-cycle `read_valid` or `write_ready` pulse after a configurable latency. It sits between the core's memory port and the data RAM region of the memory map, and lets the core's load/store path be exercised with realistic multi-cycle responses.

## Interface
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `DEPTH_WORDS`, 4096: array depth in 32-bit words; power of two, ≥2.
- `LATENCY`, 1: cycles from the accept edge to the response cycle; ≥1.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0).
- `address`  in  32  byte address; sampled at accept.
- `read_enable`  in  1  read request, level; held by the core until `read_valid`.
- `read_data`  out  32  read word; valid while `read_valid`=1; holds its value otherwise.
- `read_valid`  out  1  one-cycle read response pulse.
- `write_data`  in  32  store data; sampled at accept.
- `write_enable`  in  1  write request, level; held by the core until `write_ready`.
- `strb`  in  4  byte-lane enables; `strb[i]` writes `write_data[8i+7:8i]`.
- `write_ready`  out  1  one-cycle write completion pulse.
- `access_fault`  out  1  fault flag on the response cycle. Present only with `DMEM_FAULT_EN`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on an edge where `read_enable` or `write_enable` is 1, accept the request. Latch `address`, `write_data`, `strb`, and the op type.
  - Next state is RESP if `LATENCY`==1; otherwise WAIT with counter = `LATENCY`-1.
- WAIT: decrement the counter each edge. Go to RESP on the edge where the counter is 1.
- RESP: the response pulse is high for exactly this cycle. The array op commits on the edge entering RESP. Next state is always IDLE.
- Request inputs are ignored in WAIT and RESP. Changes to `address`/`write_data` after accept have no effect.
- Both enables high at accept: treat as a write. Only `write_ready` pulses; the read is dropped.
- Read: `read_data` = array[idx], where idx = (latched address − `BASE_ADDR`)[log2(DEPTH_WORDS)+1:2]. `strb` is ignored.
- Write: update only the lanes set in `strb`. `strb`=0 changes no memory but still pulses `write_ready`.
- Address arithmetic is unsigned modulo 2^32. Without the fault feature, out-of-range addresses wrap modulo the depth and `address[1:0]` is ignored.

## Timing
- Reset (rst=0, asynchronous): state IDLE, counter 0, `read_valid`=0, `write_ready`=0, `read_data`=0, `access_fault`=0.
- The array is not reset. Reset asserted in WAIT aborts the request; a pending write is never performed.
- Accept edge at the end of cycle A; the response pulse occurs in cycle A+`LATENCY`.
- Throughput: one request per `LATENCY`+1 cycles. An enable still high in the cycle after RESP is a new request, accepted at the end of that cycle.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `DMEM_FAULT_EN` defined:
  - Adds the `access_fault` port and its logic.
  - A request faults if `address[1:0]`≠0 or the address lies outside [`BASE_ADDR`, `BASE_ADDR`+4·`DEPTH_WORDS`).
  - A faulting write leaves memory unmodified. A faulting read returns `read_data`=0.
  - `access_fault`=1 during the response cycle; the normal `read_valid`/`write_ready` pulse still occurs.
- `DMEM_FAULT_EN` undefined: no port, no checks, wrap/ignore behaviour as in Operation.

## Test plan
- Reset then idle: all outputs 0; no pulses for 20 cycles with enables low.
- `LATENCY`=1: write 32'hDEAD_BEEF to 32'h8000_0010 with `strb`=4'hF, then read the same address. `write_ready` occurs 1 cycle after accept; `read_data`=32'hDEAD_BEEF with `read_valid` 1 cycle after accept.
- Byte strobes: write 32'h1122_3344 to 32'h8000_0020 with `strb`=4'hF, then write 32'hAABB_CCDD with `strb`=4'b0101. A read returns 32'h11BB_33DD.
- `LATENCY`=3 with enable held through response: pulses in cycles A+3 and A+7 (second accept at A+4). `address` changed mid-WAIT does not alter the result.
- Both enables high on 32'h8000_0040: only `write_ready` pulses and the memory is updated. Reset asserted in WAIT of a write to 32'h8000_0044: no pulse, and a later read returns the old contents.
- `DMEM_FAULT_EN`: read at 32'h8000_0002 and at 32'h7FFF_FFFC gives `read_valid`=1, `access_fault`=1, `read_data`=0. A write at 32'h8000_4000 (`DEPTH_WORDS`=4096) faults and does not modify word 0.
